// File: rtl/relogio_pkg.sv
// relogio_pkg: edit FSM encoding, BCD limits and the digit-pair step helper.
package relogio_pkg;
  typedef enum logic [1:0] {IDLE, EDIT_H, EDIT_M, COMMIT} state_t;
  localparam logic [7:0] HOUR_MAX = 8'd23;
  localparam logic [7:0] MIN_MAX = 8'd59;
  // Wraps within 0..max; out-of-range inputs land on a valid value.
  function automatic logic [7:0] bcd_step(input logic [3:0] t, input logic [3:0] u,
                                          input logic [7:0] max, input logic up);
    logic [7:0] v, n;
    v = {4'd0, t} * 8'd10 + {4'd0, u};
    n = up ? (v >= max ? 8'd0 : v + 8'd1) : (v == 8'd0 || v > max ? max : v - 8'd1);
    return {4'(n / 8'd10), 4'(n % 8'd10)};
  endfunction
endpackage

// File: rtl/ajuste_debounce.sv
// ajuste_debounce: 2-flop synchronizer, stability counter and rising-edge press pulse.
module ajuste_debounce #(
  parameter int DEB_CYCLES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  logic s1, s2, lvl, lvl_q;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      lvl <= 1'b0;
      lvl_q <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      lvl_q <= lvl;
      if (s2 == lvl) cnt <= '0;
      else if (cnt == CW'(DEB_CYCLES - 1)) begin
        lvl <= s2;
        cnt <= '0;
      end else cnt <= cnt + CW'(1);
    end
  end
  assign press = lvl & ~lvl_q;
endmodule

// File: rtl/relogio_ajuste.sv
// relogio_ajuste: button-driven hour/minute editor feeding the relogio load interface.
module relogio_ajuste
  import relogio_pkg::*;
#(
  parameter int DEB_CYCLES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic       btn_cancel,
  input  logic [1:0] cur_H1,
  input  logic [3:0] cur_H0,
  input  logic [3:0] cur_M1,
  input  logic [3:0] cur_M0,
  output logic [1:0] H_in1,
  output logic [3:0] H_in0,
  output logic [3:0] M_in1,
  output logic [3:0] M_in0,
  output logic       LD_time,
  output logic       editing,
  output logic       sel_min
);
  state_t st, nxt;
  logic [1:0] h1, h1_n;
  logic [3:0] h0, h0_n, m1, m1_n, m0, m0_n;
  logic ev_mode, ev_inc, ev_dec, ev_cancel, adj;
  logic [5:0] h_step;
  logic [7:0] m_step;
  ajuste_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_mode (.clk, .reset, .btn(btn_mode), .press(ev_mode));
  ajuste_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_inc (.clk, .reset, .btn(btn_inc), .press(ev_inc));
  ajuste_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_dec (.clk, .reset, .btn(btn_dec), .press(ev_dec));
  ajuste_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_cancel (.clk, .reset, .btn(btn_cancel), .press(ev_cancel));
  // inc and dec in the same cycle cancel each other out
  assign adj = ev_inc ^ ev_dec;
  assign h_step = 6'(bcd_step({2'b00, h1}, h0, HOUR_MAX, ev_inc));
  assign m_step = bcd_step(m1, m0, MIN_MAX, ev_inc);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st <= IDLE;
      h1 <= '0;
      h0 <= '0;
      m1 <= '0;
      m0 <= '0;
    end else begin
      st <= nxt;
      h1 <= h1_n;
      h0 <= h0_n;
      m1 <= m1_n;
      m0 <= m0_n;
    end
  end
  always_comb begin
    nxt = st;
    {h1_n, h0_n, m1_n, m0_n} = {h1, h0, m1, m0};
    case (st)
      IDLE: if (ev_mode) begin
        nxt = EDIT_H;
        {h1_n, h0_n, m1_n, m0_n} = {cur_H1, cur_H0, cur_M1, cur_M0};
      end
      EDIT_H: begin
        nxt = ev_cancel ? IDLE : ev_mode ? EDIT_M : EDIT_H;
        if (!ev_cancel && !ev_mode && adj) {h1_n, h0_n} = h_step;
      end
      EDIT_M: begin
        nxt = ev_cancel ? IDLE : ev_mode ? COMMIT : EDIT_M;
        if (!ev_cancel && !ev_mode && adj) {m1_n, m0_n} = m_step;
      end
      default: nxt = IDLE;
    endcase
  end
  assign {H_in1, H_in0, M_in1, M_in0} = {h1, h0, m1, m0};
  assign LD_time = st == COMMIT;
  assign editing = st == EDIT_H || st == EDIT_M;
  assign sel_min = st == EDIT_M;
endmodule

// File: tb/tb_relogio_ajuste.sv
// tb_relogio_ajuste: directed button sequences against hand-computed BCD times.
module tb_relogio_ajuste;
  logic clk = 1'b0, reset = 1'b0;
  logic btn_mode = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0, btn_cancel = 1'b0;
  logic [1:0] cur_H1 = '0, H_in1;
  logic [3:0] cur_H0 = '0, cur_M1 = '0, cur_M0 = '0, H_in0, M_in1, M_in0;
  logic LD_time, editing, sel_min;
  logic [13:0] out_t, ld_val = '0;
  int checks = 0, errors = 0, ld_cnt = 0, base;
  logic got;
  localparam logic [3:0] MODE = 4'b0001, INC = 4'b0010, DEC = 4'b0100, CAN = 4'b1000;

  relogio_ajuste #(.DEB_CYCLES(3)) dut (
    .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .btn_cancel(btn_cancel), .cur_H1(cur_H1), .cur_H0(cur_H0), .cur_M1(cur_M1), .cur_M0(cur_M0),
    .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
    .LD_time(LD_time), .editing(editing), .sel_min(sel_min)
  );

  always #5 clk = ~clk;
  assign out_t = {H_in1, H_in0, M_in1, M_in0};

  always @(negedge clk) if (LD_time) begin
    ld_cnt <= ld_cnt + 1;
    ld_val <= out_t;
  end

  function automatic logic [13:0] bcd(input int h, input int m);
    return {2'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_cur(input int h, input int m);
    {cur_H1, cur_H0, cur_M1, cur_M0} = bcd(h, m);
  endtask

  task automatic press(input logic [3:0] b);
    @(negedge clk);
    {btn_cancel, btn_dec, btn_inc, btn_mode} = b;
    repeat (10) @(negedge clk);
    {btn_cancel, btn_dec, btn_inc, btn_mode} = 4'b0000;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    set_cur(10, 19);
    repeat (3) @(negedge clk);
    check("rst_out", out_t, 0);
    check("rst_ld", LD_time, 0);
    check("rst_edit", editing, 0);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_out", out_t, 0);
    check("idle_ld", LD_time, 0);
    check("idle_edit", editing, 0);

    press(MODE);
    check("snap_edit", editing, 1);
    check("snap_sel", sel_min, 0);
    check("snap_val", out_t, bcd(10, 19));
    press(INC);
    press(INC);
    check("h_inc2", out_t, bcd(12, 19));
    press(MODE);
    check("sel_min", sel_min, 1);
    press(INC);
    check("m_inc", out_t, bcd(12, 20));
    base = ld_cnt;
    press(MODE);
    check("ld_once", ld_cnt - base, 1);
    check("ld_val", ld_val, bcd(12, 20));
    check("post_edit", editing, 0);
    check("post_val", out_t, bcd(12, 20));

    set_cur(23, 59);
    press(MODE);
    check("snap2", out_t, bcd(23, 59));
    press(INC);
    check("h_wrap_up", out_t, bcd(0, 59));
    press(DEC);
    check("h_wrap_dn", out_t, bcd(23, 59));
    press(MODE);
    press(INC);
    check("m_wrap_up", out_t, bcd(23, 0));
    press(DEC);
    check("m_wrap_dn", out_t, bcd(23, 59));
    press(CAN);
    check("can1_edit", editing, 0);
    check("can1_val", out_t, bcd(23, 59));

    set_cur(23, 9);
    press(MODE);
    press(MODE);
    press(INC);
    check("m_carry", out_t, bcd(23, 10));
    press(DEC);
    check("m_borrow", out_t, bcd(23, 9));

    @(negedge clk) btn_inc = 1'b1;
    @(negedge clk) btn_inc = 1'b0;
    repeat (15) @(negedge clk);
    check("glitch", out_t, bcd(23, 9));
    btn_inc = 1'b1;
    repeat (50) @(negedge clk);
    btn_inc = 1'b0;
    repeat (10) @(negedge clk);
    check("held", out_t, bcd(23, 10));

    base = ld_cnt;
    press(CAN);
    check("can2_edit", editing, 0);
    check("can2_val", out_t, bcd(23, 10));
    check("can2_ld", ld_cnt - base, 0);

    set_cur(5, 30);
    press(MODE);
    check("snap3", out_t, bcd(5, 30));
    press(INC | DEC);
    check("inc_dec", out_t, bcd(5, 30));
    press(MODE | INC);
    check("mode_inc_sel", sel_min, 1);
    check("mode_inc_val", out_t, bcd(5, 30));

    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("arst_m_edit", editing, 0);
    check("arst_m_sel", sel_min, 0);
    check("arst_m_val", out_t, 0);
    check("arst_m_ld", LD_time, 0);
    @(negedge clk) reset = 1'b1;
    repeat (5) @(negedge clk);

    base = ld_cnt;
    press(MODE);
    press(MODE);
    btn_mode = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (LD_time) begin
        got = 1'b1;
        break;
      end
    end
    check("commit_seen", got, 1);
    #2 reset = 1'b0;
    #1;
    check("arst_c_ld", LD_time, 0);
    check("arst_c_val", out_t, 0);
    check("arst_c_edit", editing, 0);
    btn_mode = 1'b0;
    repeat (20) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    check("arst_c_noload", ld_cnt - base, 0);
    check("arst_c_idle", editing, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
